// File: rtl/tile_line_serializer.sv
// tile_line_serializer
//
// Re-serializes m-element result tiles into a raster pixel stream, one element
// per cycle, and tracks the column/row of the element on the output. A 2-entry
// tile FIFO sits between the two valid/ready interfaces so that upstream and
// downstream can stall independently.
//
// Parameters:
//   W   pixels per output line (multiple of m)
//   H   lines per frame
//   m   elements per input tile
//   DW  bits per element
//
// Ports:
//   i_clk            clock, rising edge
//   i_rst            asynchronous active-low reset
//   i_tile           input tile, element j at bits [(m-1-j)*DW +: DW]
//   i_tile_valid     i_tile is valid
//   o_tile_ready     a tile can be accepted this cycle
//   o_data           current element
//   o_data_valid     o_data is valid
//   i_data_ready     downstream accepts o_data
//   o_last_in_line   o_data is at column W-1
//   o_last_in_frame  o_data is at column W-1 of row H-1
//   o_col, o_row     position of o_data in the frame

module tile_line_serializer #(
    parameter int unsigned W  = 512,
    parameter int unsigned H  = 512,
    parameter int unsigned m  = 2,
    parameter int unsigned DW = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [m*DW-1:0]      i_tile,
    input  logic                 i_tile_valid,
    output logic                 o_tile_ready,
    output logic [DW-1:0]        o_data,
    output logic                 o_data_valid,
    input  logic                 i_data_ready,
    output logic                 o_last_in_line,
    output logic                 o_last_in_frame,
    output logic [$clog2(W)-1:0] o_col,
    output logic [$clog2(H)-1:0] o_row
);

    localparam int unsigned TW = m * DW;
    localparam int unsigned CW = $clog2(W);
    localparam int unsigned RW = $clog2(H);
    localparam int unsigned EW = (m > 1) ? $clog2(m) : 1;

    logic [TW-1:0] tile_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    count_q;
    logic [1:0]    count_d;
    logic [EW-1:0] elem_idx_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    // Holds o_tile_ready low during reset and until the first edge after release.
    logic          rst_done_q;

    logic          tile_ready;
    logic          data_valid;
    logic          push;
    logic          xfer;
    logic          last_elem;
    logic          pop;
    logic          col_wrap;
    logic [TW-1:0] head;
    logic [DW-1:0] head_elem;

    assign tile_ready = rst_done_q && (count_q != 2'd2);
    assign data_valid = (count_q != 2'd0);
    assign push       = i_tile_valid && tile_ready;
    assign xfer       = data_valid && i_data_ready;
    assign last_elem  = (elem_idx_q == EW'(m - 1));
    assign pop        = xfer && last_elem;
    assign col_wrap   = (col_q == CW'(W - 1));

    // Element select from the registered head tile; leftmost pixel sits in the MSBs.
    always_comb begin
        head      = tile_q[rd_ptr_q];
        head_elem = '0;
        for (int unsigned j = 0; j < m; j++) begin
            if (elem_idx_q == EW'(j)) begin
                head_elem = head[(m-1-j)*DW +: DW];
            end
        end
    end

    // A simultaneous push and pop leaves the occupancy unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            tile_q[0]  <= '0;
            tile_q[1]  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            elem_idx_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            rst_done_q <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            count_q    <= count_d;

            if (push) begin
                tile_q[wr_ptr_q] <= i_tile;
                wr_ptr_q         <= ~wr_ptr_q;
            end

            if (xfer) begin
                if (last_elem) begin
                    elem_idx_q <= '0;
                    rd_ptr_q   <= ~rd_ptr_q;
                end else begin
                    elem_idx_q <= elem_idx_q + EW'(1);
                end

                if (col_wrap) begin
                    col_q <= '0;
                    if (row_q == RW'(H - 1)) begin
                        row_q <= '0;
                    end else begin
                        row_q <= row_q + RW'(1);
                    end
                end else begin
                    col_q <= col_q + CW'(1);
                end
            end
        end
    end

    assign o_tile_ready    = tile_ready;
    assign o_data_valid    = data_valid;
    assign o_data          = data_valid ? head_elem : '0;
    assign o_col           = col_q;
    assign o_row           = row_q;
    assign o_last_in_line  = data_valid && col_wrap;
    assign o_last_in_frame = data_valid && col_wrap && (row_q == RW'(H - 1));

endmodule

// File: tb/tb_tile_line_serializer.sv
// Bench for tile_line_serializer with W=8, H=2, m=2, DW=8. A pixel queue models
// the block: accepted tiles append their elements in raster order, transfers
// pop the front, and position follows from the number of transfers so far.

module tb_tile_line_serializer;

    localparam int unsigned W  = 8;
    localparam int unsigned H  = 2;
    localparam int unsigned M  = 2;
    localparam int unsigned DW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [M*DW-1:0] tile;
    logic            tile_valid;
    logic            tile_ready;
    logic [DW-1:0]   data;
    logic            data_valid;
    logic            data_ready;
    logic            last_in_line;
    logic            last_in_frame;
    logic [2:0]      col;
    logic [0:0]      row;

    always #5 clk = ~clk;

    tile_line_serializer #(
        .W  (W),
        .H  (H),
        .m  (M),
        .DW (DW)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_tile          (tile),
        .i_tile_valid    (tile_valid),
        .o_tile_ready    (tile_ready),
        .o_data          (data),
        .o_data_valid    (data_valid),
        .i_data_ready    (data_ready),
        .o_last_in_line  (last_in_line),
        .o_last_in_frame (last_in_frame),
        .o_col           (col),
        .o_row           (row)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model state.
    byte unsigned pq[$];
    int unsigned  n_xfer     = 0;
    bit           ready_en_m = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a falling edge: check outputs, drive inputs for the next rising
    // edge, advance the model past that edge, then wait for the next falling edge.
    task automatic cycle(input bit tv, input logic [M*DW-1:0] t, input bit dr, output bit acc);
        bit          ev;
        bit          er;
        bit          lil;
        int unsigned ecol;
        int unsigned erow;
        ev   = (pq.size() > 0);
        er   = ready_en_m && (((pq.size() + M - 1) / M) < 2);
        ecol = n_xfer % W;
        erow = (n_xfer / W) % H;
        lil  = ev && (ecol == W - 1);

        check_val("tile_ready", 32'(tile_ready), 32'(er));
        check_val("data_valid", 32'(data_valid), 32'(ev));
        if (ev) check_val("data", 32'(data), 32'(pq[0]));
        check_val("col", 32'(col), ecol);
        check_val("row", 32'(row), erow);
        check_val("last_in_line", 32'(last_in_line), 32'(lil));
        check_val("last_in_frame", 32'(last_in_frame), 32'(lil && (erow == H - 1)));

        tile_valid = tv;
        tile       = t;
        data_ready = dr;

        acc = tv && er;
        if (ev && dr) begin
            void'(pq.pop_front());
            n_xfer++;
        end
        if (acc) begin
            for (int j = 0; j < M; j++) pq.push_back(t[(M-1-j)*DW +: DW]);
        end
        ready_en_m = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        tile_valid = 1'b0;
        tile       = '0;
        data_ready = 1'b0;
        #1;
        check_val("rst_data", 32'(data), 32'h0);
        check_val("rst_data_valid", 32'(data_valid), 32'h0);
        check_val("rst_tile_ready", 32'(tile_ready), 32'h0);
        check_val("rst_col", 32'(col), 32'h0);
        check_val("rst_row", 32'(row), 32'h0);
        check_val("rst_last_in_line", 32'(last_in_line), 32'h0);
        check_val("rst_last_in_frame", 32'(last_in_frame), 32'h0);
        pq.delete();
        n_xfer     = 0;
        ready_en_m = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Hold a tile on the input until it is taken, bounded.
    task automatic offer(input logic [M*DW-1:0] t, input bit dr);
        bit acc;
        int k;
        acc = 1'b0;
        k   = 0;
        while (!acc && k < 8) begin
            cycle(1'b1, t, dr, acc);
            k++;
        end
        if (!acc) check_val("accept_timeout", 32'h0, 32'h1);
    endtask

    task automatic run_random(input int n, input int unsigned pv, input int unsigned pr);
        bit              pend;
        bit              acc;
        logic [M*DW-1:0] t;
        pend = 1'b0;
        t    = '0;
        for (int i = 0; i < n; i++) begin
            if (!pend && ($urandom_range(99) < pv)) begin
                pend = 1'b1;
                t    = (M*DW)'($urandom);
            end
            cycle(pend, t, $urandom_range(99) < pr, acc);
            if (acc) pend = 1'b0;
        end
    endtask

    bit acc;

    initial begin
        do_reset();

        // Single tile drains in two cycles.
        cycle(1'b1, 16'hABCD, 1'b1, acc);
        repeat (4) cycle(1'b0, '0, 1'b1, acc);

        // Backpressure holds the first element.
        cycle(1'b1, 16'h1234, 1'b0, acc);
        repeat (5) cycle(1'b0, '0, 1'b0, acc);
        repeat (3) cycle(1'b0, '0, 1'b1, acc);

        // FIFO full: third tile waits for the first pop.
        cycle(1'b1, 16'h1111, 1'b0, acc);
        cycle(1'b1, 16'h2222, 1'b0, acc);
        repeat (3) cycle(1'b1, 16'h3333, 1'b0, acc);
        offer(16'h3333, 1'b1);
        repeat (8) cycle(1'b0, '0, 1'b1, acc);

        // Reset mid-line with two tiles buffered.
        cycle(1'b1, 16'h0102, 1'b1, acc);
        cycle(1'b1, 16'h0304, 1'b0, acc);
        cycle(1'b1, 16'h0506, 1'b0, acc);
        do_reset();
        cycle(1'b0, '0, 1'b1, acc);
        cycle(1'b1, 16'h5566, 1'b1, acc);
        repeat (3) cycle(1'b0, '0, 1'b1, acc);

        // Full frame of pixel values 0..15 under continuous traffic.
        do_reset();
        for (int k = 0; k < 8; k++) offer({8'(2 * k), 8'(2 * k + 1)}, 1'b1);
        repeat (4) cycle(1'b0, '0, 1'b1, acc);

        // Randomized traffic: streaming, mixed, heavy backpressure.
        run_random(300, 100, 100);
        run_random(600, 50, 50);
        run_random(400, 80, 25);
        run_random(400, 30, 90);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
